// File: rtl/serial_src_pkg.sv
// Shared types and defaults for the serial bit source and its FIFO.
package serial_src_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Counter width able to index 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an explicit occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is read combinationally so a pop can load the shifter on the same edge.
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/serial_bit_source.sv
// Buffers parallel words and shifts them out one bit per clock on A, gap-free
// between consecutive buffered words.
module serial_bit_source
    import serial_src_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             A,
    output logic             A_valid,
    output logic             busy,
    output logic [15:0]      words_sent
);
    localparam int CW = cnt_w(WIDTH);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [15:0]      words_q, words_d;

    logic                   push;
    logic                   pop;
    logic [WIDTH-1:0]       fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   last_bit;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready depends only on the registered count, never on this cycle's pop.
    assign din_ready = !fifo_full;
    assign push      = din_valid && din_ready;
    assign last_bit  = (bitcnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        words_d  = words_q;
        pop      = 1'b0;
        if (state_q == S_IDLE) begin
            if (!fifo_empty) begin
                pop      = 1'b1;
                shreg_d  = fifo_dout;
                bitcnt_d = '0;
                state_d  = S_SHIFT;
            end
        end else begin
            shreg_d  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            bitcnt_d = bitcnt_q + 1'b1;
            if (last_bit) begin
                words_d  = words_q + 16'd1;
                bitcnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            words_q  <= words_d;
        end
    end

    assign A_valid    = (state_q == S_SHIFT);
    assign A          = A_valid ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_BIT;
    assign busy       = (state_q == S_SHIFT) || (fifo_count != '0);
    assign words_sent = words_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: default MSB-first instance plus an
// LSB-first instance idling high.
module tb_serial_bit_source;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din, din2;
    logic        din_valid, din_valid2;
    logic        din_ready, A, A_valid, busy;
    logic        din_ready2, A2, A_valid2, busy2;
    logic [15:0] words_sent, words_sent2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_bit_source dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .A          (A),
        .A_valid    (A_valid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    serial_bit_source #(
        .WIDTH     (8),
        .DEPTH     (4),
        .MSB_FIRST (1'b0),
        .IDLE_BIT  (1'b1)
    ) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .din        (din2),
        .din_valid  (din_valid2),
        .din_ready  (din_ready2),
        .A          (A2),
        .A_valid    (A_valid2),
        .busy       (busy2),
        .words_sent (words_sent2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs and samples both sit 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0]  word;
        logic [15:0] pair;
        logic [7:0]  sw;
        logic        rdy;
        int          acc, full_acc, last_cyc, exp_word, bitn, gaps, stale;
        bit          started;

        reset = 1'b0; din = '0; din_valid = 1'b0; din2 = '0; din_valid2 = 1'b0;
        tick();
        tick();
        // Reset state (reset still asserted)
        check("rst_A", A, 0);
        check("rst_A_valid", A_valid, 0);
        check("rst_din_ready", din_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_words_sent", words_sent, 0);
        check("rst_A_lsb_idle", A2, 1);
        reset = 1'b1;
        tick();

        // Single word 0xB5, MSB first
        sw = 8'hB5;
        din = sw; din_valid = 1'b1;
        tick();                              // E0: accepted
        din_valid = 1'b0;
        check("single_wait_valid", A_valid, 0);
        check("single_busy", busy, 1);
        tick();                              // E0+1: popped
        for (int i = 0; i < 8; i++) begin
            check($sformatf("single_bit%0d", i), A, sw[7-i]);
            check($sformatf("single_valid%0d", i), A_valid, 1);
            tick();
        end
        check("single_after_valid", A_valid, 0);
        check("single_after_A", A, 0);
        check("single_words", words_sent, 1);
        check("single_after_busy", busy, 0);

        // Back-to-back 0xBE, 0xC0
        pair = 16'hBEC0;
        din = 8'hBE; din_valid = 1'b1;
        tick();
        din = 8'hC0;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b_bit%0d", i), A, pair[15-i]);
            check($sformatf("b2b_valid%0d", i), A_valid, 1);
            tick();
        end
        check("b2b_after_valid", A_valid, 0);
        check("b2b_words", words_sent, 3);

        // Backpressure with incrementing data
        do_reset();
        tick();
        din = 8'h00; din_valid = 1'b1;
        acc = 0; full_acc = -1; last_cyc = 0; exp_word = 0; bitn = 0; gaps = 0;
        word = '0; started = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            rdy = din_ready;
            if (!rdy && full_acc < 0) full_acc = acc;
            if (A_valid) begin
                started = 1'b1;
                word = {word[6:0], A};
                bitn++;
                if (bitn == 8) begin
                    check("bp_order", word, exp_word);
                    exp_word++;
                    bitn = 0;
                end
            end else if (started) begin
                gaps++;
            end
            tick();
            if (rdy) begin
                acc++;
                if (acc >= 7) check("bp_period", cyc - last_cyc, 8);
                last_cyc = cyc;
                din = din + 8'd1;
            end
        end
        din_valid = 1'b0;
        check("bp_accept_before_full", full_acc, 5);
        check("bp_gaps", gaps, 0);
        check("bp_enough_words", (exp_word >= 10), 1);

        // Reset during bit 3 with two words buffered
        do_reset();
        din = 8'hAA; din_valid = 1'b1;
        tick();                              // E0
        din = 8'h55;
        tick();                              // E1: AA loaded
        din = 8'h0F;
        tick();                              // E2
        din_valid = 1'b0;
        tick();                              // E3
        tick();                              // E4: bit 3 on A
        check("mid_bit3_valid", A_valid, 1);
        check("mid_bit3_A", A, 0);
        reset = 1'b0;
        din = 8'hFF; din_valid = 1'b1;       // must be ignored during reset
        tick();
        din_valid = 1'b0;
        check("mid_rst_A", A, 0);
        check("mid_rst_A_valid", A_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_din_ready", din_ready, 1);
        check("mid_rst_words", words_sent, 0);
        reset = 1'b1;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            if (A_valid) stale++;
            tick();
        end
        check("mid_no_stale", stale, 0);
        din = 8'h3C; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        word = '0;
        for (int i = 0; i < 8; i++) begin
            word = {word[6:0], A};
            tick();
        end
        check("mid_fresh_word", word, 8'h3C);
        check("mid_fresh_count", words_sent, 1);

        // LSB-first, idle high, push 0x01
        check("lsb_idle_before", A2, 1);
        din2 = 8'h01; din_valid2 = 1'b1;
        tick();
        din_valid2 = 1'b0;
        check("lsb_idle_wait", A2, 1);
        check("lsb_wait_valid", A_valid2, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb_bit%0d", i), A2, (i == 0) ? 1 : 0);
            check($sformatf("lsb_valid%0d", i), A_valid2, 1);
            tick();
        end
        check("lsb_idle_after", A2, 1);
        check("lsb_after_valid", A_valid2, 0);
        check("lsb_words", words_sent2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
